// File: rtl/lfsr_rng_pkg.sv
// Shared definitions for the LFSR random-number arbiter.
// Holds the two-state FSM encoding and the default 32-bit tap mask and seed.
// The counter widths are also kept here so the top and the bench agree on them.
package lfsr_rng_pkg;

  // WARM: the LFSR is free-running to discard the first steps after a (re)seed.
  // RUN:  the LFSR only advances when a grant is issued.
  typedef enum logic [0:0] {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Default Galois tap mask; bit 31 is implied by the feedback into the MSB.
  localparam logic [31:0] DEF_POLY32 = 32'h8020_0003;
  // Default seed; it also replaces a zero seed so the LFSR never locks up.
  localparam logic [31:0] DEF_SEED32 = 32'hACE1_ACE1;

  // The warm counter must reach WARMUP_CYC, which is at most 255.
  localparam int unsigned WARM_CNT_W = 8;
  // The grant counter wraps at 16 bits.
  localparam int unsigned GNT_CNT_W  = 16;

endpackage

// File: rtl/lfsr_rng_rr_arb.sv
// Round-robin selector for the LFSR random-number arbiter.
// Purely combinational: the last-winner register lives in the parent.
// Ports:
//   req   - eligible requesters (already masked by the parent)
//   last  - index of the previous winner; the search starts just after it
//   gnt   - one-hot grant vector, zero when nobody is eligible
//   idx   - binary index of the winner (0 when valid is low)
//   valid - at least one requester was eligible
module lfsr_rng_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [IDX_W-1:0] cand_s;

  // Walk the ring once, starting after the last winner; first hit wins.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    valid  = 1'b0;
    cand_s = last;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Explicit wrap so non-power-of-two ring sizes never index past the end.
      if (cand_s == IDX_W'(NUM_REQ - 1)) begin
        cand_s = '0;
      end else begin
        cand_s = cand_s + IDX_W'(1);
      end
      if (!valid && req[cand_s]) begin
        valid       = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/lfsr_rng_arb.sv
// Round-robin arbiter that hands out one LFSR random word per grant.
// After reset or a seed load the Galois LFSR free-runs for WARMUP_CYC steps
// (busy_o high, no grants); afterwards it advances only on grants.
// Ports:
//   clk_i     - clock, rising edge
//   rst_i     - synchronous active-high reset
//   seed_wr_i - one-cycle seed load strobe (zero seed maps to DEF_SEED)
//   seed_i    - seed value
//   req_i     - per-requester request levels
//   gnt_o     - registered one-hot-or-zero grant pulse
//   rnd_o     - registered random word, valid with a nonzero gnt_o
//   busy_o    - high while warming up
//   gnt_cnt_o - wrapping count of grants since reset
module lfsr_rng_arb
  import lfsr_rng_pkg::*;
#(
  parameter int                    NUM_REQ    = 4,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] POLY       = DATA_WIDTH'(DEF_POLY32),
  parameter logic [DATA_WIDTH-1:0] DEF_SEED   = DATA_WIDTH'(DEF_SEED32),
  parameter int                    WARMUP_CYC = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  seed_wr_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  input  logic [NUM_REQ-1:0]    req_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  output logic [DATA_WIDTH-1:0] rnd_o,
  output logic                  busy_o,
  output logic [GNT_CNT_W-1:0]  gnt_cnt_o
);

  localparam int                    IDX_W     = $clog2(NUM_REQ);
  localparam logic [WARM_CNT_W-1:0] WARM_LAST = WARM_CNT_W'(WARMUP_CYC);
  localparam logic [IDX_W-1:0]      LAST_RST  = IDX_W'(NUM_REQ - 1);

  // One Galois step: the LSB falls out, feeds the MSB and XORs into the taps.
  // A nonzero state can never step to zero, because a set LSB always sets the MSB.
  function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] q);
    logic [DATA_WIDTH-1:0] n;
    n[DATA_WIDTH-1] = q[0];
    for (int i = 0; i < DATA_WIDTH - 1; i++) begin
      n[i] = q[i+1] ^ (POLY[i] & q[0]);
    end
    return n;
  endfunction

  state_e                  state_r,   state_s;
  logic [WARM_CNT_W-1:0]   warm_cnt_r, warm_cnt_s;
  logic [DATA_WIDTH-1:0]   lfsr_r,    lfsr_s;
  logic [IDX_W-1:0]        last_r,    last_s;
  logic [NUM_REQ-1:0]      gnt_r,     gnt_s;
  logic [DATA_WIDTH-1:0]   rnd_r,     rnd_s;
  logic [GNT_CNT_W-1:0]    gnt_cnt_r, gnt_cnt_s;
  logic                    busy_r;

  logic [NUM_REQ-1:0]      elig_s;
  logic [NUM_REQ-1:0]      arb_gnt_s;
  logic [IDX_W-1:0]        arb_idx_s;
  logic                    arb_valid_s;

  // A requester granted this cycle sits out one cycle, even if still requesting.
  assign elig_s = req_i & ~gnt_r;

  lfsr_rng_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arb (
    .req   (elig_s),
    .last  (last_r),
    .gnt   (arb_gnt_s),
    .idx   (arb_idx_s),
    .valid (arb_valid_s)
  );

  // Next-state and next-output logic; a seed load overrides any grant decision.
  always_comb begin
    state_s    = state_r;
    warm_cnt_s = warm_cnt_r;
    lfsr_s     = lfsr_r;
    last_s     = last_r;
    gnt_s      = '0;
    rnd_s      = rnd_r;
    gnt_cnt_s  = gnt_cnt_r;
    if (seed_wr_i) begin
      lfsr_s     = (seed_i == '0) ? DEF_SEED : seed_i;
      warm_cnt_s = '0;
      state_s    = WARM;
    end else begin
      case (state_r)
        WARM: begin
          lfsr_s     = lfsr_step(lfsr_r);
          warm_cnt_s = warm_cnt_r + WARM_CNT_W'(1);
          if (warm_cnt_s == WARM_LAST) begin
            state_s = RUN;
          end else begin
            state_s = WARM;
          end
        end
        RUN: begin
          if (arb_valid_s) begin
            gnt_s     = arb_gnt_s;
            rnd_s     = lfsr_r;
            lfsr_s    = lfsr_step(lfsr_r);
            last_s    = arb_idx_s;
            gnt_cnt_s = gnt_cnt_r + GNT_CNT_W'(1);
          end else begin
            gnt_s = '0;
          end
        end
        default: begin
          state_s    = WARM;
          warm_cnt_s = '0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= WARM;
      warm_cnt_r <= '0;
      lfsr_r     <= DEF_SEED;
      last_r     <= LAST_RST;
      gnt_r      <= '0;
      rnd_r      <= '0;
      gnt_cnt_r  <= '0;
      busy_r     <= 1'b1;
    end else begin
      state_r    <= state_s;
      warm_cnt_r <= warm_cnt_s;
      lfsr_r     <= lfsr_s;
      last_r     <= last_s;
      gnt_r      <= gnt_s;
      rnd_r      <= rnd_s;
      gnt_cnt_r  <= gnt_cnt_s;
      busy_r     <= (state_s == WARM);
    end
  end

  assign gnt_o     = gnt_r;
  assign rnd_o     = rnd_r;
  assign busy_o    = busy_r;
  assign gnt_cnt_o = gnt_cnt_r;

endmodule

// File: tb/tb_lfsr_rng_arb.sv
// Self-checking bench for lfsr_rng_arb: a default-parameter instance checked
// every cycle against a behavioural model, plus a 4-bit instance for a small
// hand-computed LFSR sequence.
module tb_lfsr_rng_arb;

  localparam logic [31:0] TB_POLY = 32'h8020_0003;
  localparam logic [31:0] TB_SEED = 32'hACE1_ACE1;
  localparam int          TB_WARM = 32;
  localparam int          TB_N    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        rst = 1'b1, seed_wr = 1'b0;
  logic [31:0] seed = 32'd0;
  logic [3:0]  req = 4'd0;
  logic [3:0]  gnt;
  logic [31:0] rnd;
  logic        busy;
  logic [15:0] gnt_cnt;

  // 4-bit instance
  logic        rst4 = 1'b1, seed_wr4 = 1'b0;
  logic [3:0]  seed4 = 4'd0;
  logic [3:0]  req4 = 4'd0;
  logic [3:0]  gnt4;
  logic [3:0]  rnd4;
  logic        busy4;
  logic [15:0] gnt_cnt4;

  lfsr_rng_arb dut (
    .clk_i(clk), .rst_i(rst), .seed_wr_i(seed_wr), .seed_i(seed), .req_i(req),
    .gnt_o(gnt), .rnd_o(rnd), .busy_o(busy), .gnt_cnt_o(gnt_cnt)
  );

  lfsr_rng_arb #(
    .NUM_REQ(4), .DATA_WIDTH(4), .POLY(4'b0001), .WARMUP_CYC(2)
  ) dut4 (
    .clk_i(clk), .rst_i(rst4), .seed_wr_i(seed_wr4), .seed_i(seed4), .req_i(req4),
    .gnt_o(gnt4), .rnd_o(rnd4), .busy_o(busy4), .gnt_cnt_o(gnt_cnt4)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [31:0] m_lfsr, m_rnd;
  bit        m_busy;
  int        m_warm, m_last, m_gidx, m_cnt;

  // shift right; if the bit shifted out was 1, it re-enters at the top and
  // toggles every tap below the top
  function automatic bit [31:0] ref_step(input bit [31:0] q);
    bit [31:0] n;
    n = q >> 1;
    if (q[0]) begin
      n = n | 32'h8000_0000;
      n = n ^ (TB_POLY & 32'h7FFF_FFFF);
    end
    return n;
  endfunction

  task automatic model_step();
    int win;
    if (rst) begin
      m_lfsr = TB_SEED; m_busy = 1'b1; m_warm = 0; m_gidx = -1;
      m_rnd = 32'd0; m_cnt = 0; m_last = TB_N - 1;
    end else if (seed_wr) begin
      m_lfsr = (seed == 32'd0) ? TB_SEED : seed;
      m_warm = 0; m_busy = 1'b1; m_gidx = -1;
    end else if (m_busy) begin
      m_lfsr = ref_step(m_lfsr);
      m_warm++;
      if (m_warm == TB_WARM) m_busy = 1'b0;
      m_gidx = -1;
    end else begin
      win = -1;
      for (int k = 1; k <= TB_N; k++) begin
        int c;
        c = (m_last + k) % TB_N;
        if (win < 0 && req[c] && c != m_gidx) win = c;
      end
      m_gidx = win;
      if (win >= 0) begin
        m_rnd  = m_lfsr;
        m_lfsr = ref_step(m_lfsr);
        m_last = win;
        m_cnt  = (m_cnt + 1) % 65536;
      end
    end
  endtask

  function automatic logic [3:0] m_gnt_vec();
    logic [3:0] v;
    v = 4'd0;
    if (m_gidx >= 0) v[m_gidx] = 1'b1;
    return v;
  endfunction

  // advance one clock and compare the default instance with the model
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("gnt", gnt, m_gnt_vec());
    chk("busy", busy, m_busy);
    chk("gnt_cnt", gnt_cnt, m_cnt[15:0]);
    chk("rnd", rnd, m_rnd);
    chk("onehot0", $onehot0(gnt), 1'b1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0]  req;
    logic        sw;
    logic [3:0]  gnt;
    logic        busy;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl[12];

  int        busy_len;
  logic [31:0] exp_rnd;
  logic [3:0]  got4[2];
  int          gcyc[2];
  int          ng;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'b0101, 1'b0, 4'b0001, 1'b0, 16'd1};
    tbl[1]  = '{4'b0101, 1'b0, 4'b0100, 1'b0, 16'd2};
    tbl[2]  = '{4'b0101, 1'b0, 4'b0001, 1'b0, 16'd3};
    tbl[3]  = '{4'b0101, 1'b0, 4'b0100, 1'b0, 16'd4};
    tbl[4]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, 16'd5};
    tbl[5]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 16'd5};
    tbl[6]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, 16'd6};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0010, 1'b0, 16'd7};
    tbl[8]  = '{4'b1111, 1'b0, 4'b0100, 1'b0, 16'd8};
    tbl[9]  = '{4'b1010, 1'b0, 4'b1000, 1'b0, 16'd9};
    tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 16'd9};
    tbl[11] = '{4'b0010, 1'b1, 4'b0000, 1'b1, 16'd9};

    // reset state
    rst = 1'b1; req = 4'b1111;
    cycle();
    chk("rst_busy", busy, 1'b1);
    chk("rst_gnt", gnt, 4'd0);
    chk("rst_cnt", gnt_cnt, 16'd0);
    chk("rst_rnd", rnd, 32'd0);

    // warmup length after reset, requests ignored meanwhile
    rst = 1'b0;
    busy_len = 1;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (busy) busy_len++;
      else break;
    end
    chk("warm_len_rst", busy_len, 32);
    chk("warm_cnt_rst", gnt_cnt, 16'd0);

    // round-robin table, ending with a seed load that drops a pending grant
    seed = 32'h1234_5678;
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req; seed_wr = tbl[i].sw;
      cycle();
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_cnt", i), gnt_cnt, tbl[i].cnt);
    end

    // warmup after seed load; counter untouched
    seed_wr = 1'b0;
    busy_len = 1;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (busy) busy_len++;
      else break;
    end
    chk("warm_len_seed", busy_len, 32);
    chk("cnt_after_seed", gnt_cnt, 16'd9);
    cycle();
    chk("first_after_seed", gnt, 4'b0010);

    // zero seed falls back to the default seed
    req = 4'd0; seed_wr = 1'b1; seed = 32'd0;
    cycle();
    seed_wr = 1'b0;
    for (int k = 0; k < TB_WARM; k++) cycle();
    req = 4'b0001;
    cycle();
    exp_rnd = TB_SEED;
    for (int k = 0; k < TB_WARM; k++) exp_rnd = ref_step(exp_rnd);
    chk("seed0_gnt", gnt, 4'b0001);
    chk("seed0_rnd", rnd, exp_rnd);

    // randomized traffic with occasional seed loads and resets
    for (int k = 0; k < 3000; k++) begin
      req     = 4'($urandom);
      seed_wr = ($urandom_range(0, 99) < 1);
      seed    = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      rst     = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0; seed_wr = 1'b0; req = 4'd0;

    // 4-bit instance: hand-computed sequence
    rst4 = 1'b1;
    cycle();
    chk("w4_rst_busy", busy4, 1'b1);
    chk("w4_rst_cnt", gnt_cnt4, 16'd0);
    rst4 = 1'b0; seed_wr4 = 1'b1; seed4 = 4'b0001;
    cycle();
    seed_wr4 = 1'b0; req4 = 4'b0001;
    ng = 0; got4[0] = 4'd0; got4[1] = 4'd0; gcyc[0] = 0; gcyc[1] = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (gnt4 != 4'd0 && ng < 2) begin
        got4[ng] = rnd4; gcyc[ng] = k; ng++;
      end
    end
    chk("w4_two_grants", ng, 2);
    chk("w4_rnd0", got4[0], 4'b1101);
    chk("w4_rnd1", got4[1], 4'b1111);
    chk("w4_spacing", gcyc[1] - gcyc[0], 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_rng_arb.md
LFSR_RNG_ARB -- requirements
Module: lfsr_rng_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters, 2..16.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: width of the random word and LFSR state, 4..64.
REQ-003 The block SHALL have parameter POLY, default 32'h8020_0003, width DATA_WIDTH: Galois tap mask, bit i taps stage i, bit DATA_WIDTH-1 ignored.
REQ-004 The block SHALL have parameter DEF_SEED, default 32'hACE1_ACE1, width DATA_WIDTH, nonzero: reset seed and zero-seed substitute.
REQ-005 The block SHALL have parameter WARMUP_CYC, default 32, range 1..255: LFSR steps discarded after each (re)seed.
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock, all logic rising-edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port seed_wr_i, input, 1 bit: one-cycle seed load strobe.
REQ-009 The block SHALL have port seed_i, input, DATA_WIDTH bits: seed value, sampled when seed_wr_i=1.
REQ-010 The block SHALL have port req_i, input, NUM_REQ bits: per-requester request level, held until granted.
REQ-011 The block SHALL have port gnt_o, output, NUM_REQ bits: registered, one-hot-or-zero grant pulse.
REQ-012 The block SHALL have port rnd_o, output, DATA_WIDTH bits: registered random word, valid only in a cycle where gnt_o is nonzero.
REQ-013 The block SHALL have port busy_o, output, 1 bit: 1 while not in RUN.
REQ-014 The block SHALL have port gnt_cnt_o, output, 16 bits: total grants since the last reset, wrapping.

Function
REQ-015 The LFSR step SHALL be next[W-1]=q[0] and next[i]=q[i+1]^(POLY[i]&q[0]) for i<W-1, where W=DATA_WIDTH.
REQ-016 The FSM SHALL have exactly two states, WARM and RUN; busy_o SHALL equal (state==WARM).
REQ-017 In WARM, the LFSR SHALL step every cycle and a warm counter SHALL increment; on the step that makes the count WARMUP_CYC, the next state SHALL be RUN.
REQ-018 In WARM, gnt_o SHALL be 0 and requests SHALL be ignored, not queued.
REQ-019 In RUN, the LFSR SHALL step only in a cycle where a grant is issued; otherwise it SHALL hold.
REQ-020 Arbitration SHALL be round-robin: the search starts at the index after the last winner; after reset the last winner is NUM_REQ-1, so index 0 has highest priority.
REQ-021 The eligible set SHALL be req_i & ~gnt_o: a requester whose gnt_o is high this cycle SHALL NOT win this cycle.
REQ-022 If cycle t is in RUN with a nonzero eligible set and seed_wr_i=0, cycle t+1 SHALL show gnt_o=onehot(winner), rnd_o=LFSR state at t, and the LFSR SHALL have stepped once.
REQ-023 Different requesters SHALL be grantable in back-to-back cycles; a single requester SHALL be granted at most every second cycle.
REQ-024 A seed_wr_i pulse SHALL take effect in either state.
REQ-025 On seed_wr_i, the LFSR SHALL load seed_i, or DEF_SEED if seed_i==0; the warm counter SHALL clear; the state SHALL go to WARM; gnt_o SHALL be 0 in the next cycle.
REQ-026 seed_wr_i SHALL take priority over a simultaneous grant decision; that grant is dropped.
REQ-027 gnt_cnt_o SHALL increment by 1 per grant and wrap from 16'hFFFF to 0; it SHALL NOT be cleared by seed_wr_i.
REQ-028 rnd_o SHALL hold its last value in cycles without a grant.
REQ-029 The LFSR state SHALL never be all-zero.

Reset
REQ-030 On rst_i=1 at a clock edge, the LFSR SHALL become DEF_SEED, the state WARM, the warm counter 0, gnt_o 0, rnd_o 0, gnt_cnt_o 0, and the last winner NUM_REQ-1; busy_o SHALL then be 1.
REQ-031 rst_i SHALL override seed_wr_i and req_i, and an in-flight grant SHALL be dropped.

Structure
REQ-032 A shared package lfsr_rng_pkg SHALL hold the FSM state enum (WARM, RUN) and constants DEF_POLY32 and DEF_SEED32.
REQ-033 The round-robin selector SHALL be the single sub-module lfsr_rng_rr_arb, which is combinational given the last-winner register held in the parent.

Verification
REQ-034 Reset with defaults: busy_o=1 for exactly 32 cycles and then 0; gnt_o=0 and gnt_cnt_o=0 throughout.
REQ-035 Parameters W=4, POLY=4'b0001, WARMUP_CYC=2, seed_i=4'b0001 strobed, then req_i[0] held: rnd_o sequence on grants is 4'b1101 then 4'b1111.
REQ-036 seed_i=0 strobed: the internal state equals DEF_SEED, and it matches a model run from DEF_SEED after warmup.
REQ-037 Defaults, req_i=4'b0101 held continuously in RUN: gnt_o sequence is 0001, 0100, 0001, 0100, with no idle cycles.
REQ-038 seed_wr_i asserted in the same cycle as a pending request in RUN: no grant in the next cycle, busy_o=1 for 32 cycles, and gnt_cnt_o unchanged.
REQ-039 Random req_i with random seed_wr_i and rst_i: rnd_o on each grant matches the model, and gnt_o is always one-hot-or-zero.
